car_datapath: RTL
=================

CAR_DATAPATH -- requirements
Module: car_datapath

Interface
REQ-001 SCREEN_W, 160, screen width in pixels.
REQ-002 SCREEN_H, 120, screen height in pixels.
REQ-003 CAR_W, 4, car sprite width.
REQ-004 CAR_H, 4, car sprite height.
REQ-005 START_X, 78, car x after reset.
REQ-006 START_Y, 100, car y after reset.
REQ-007 STEP, 2, pixels moved per move command.
REQ-008 BG_COLOUR, 3'b010, background/erase colour; CAR_COLOUR, 3'b100, car colour.
REQ-009 clock  in  1  system clock; reset is synchronous, active-high, named reset.
REQ-010 reset  in  1  synchronous active-high reset.
REQ-011 draw_bg, draw_car, erase  in  1 each  level fill requests, held by the controller for the duration of a fill.
REQ-012 move_straight, move_left, move_right  in  1 each  single-cycle move commands.
REQ-013 counterx  out  8  current column offset within the active fill; terminal value when done.
REQ-014 countery  out  8  current row offset within the active fill.
REQ-015 fill_done  out  1  high while a completed fill's request is still held.
REQ-016 vga_x  out  8, vga_y  out  7, vga_colour  out  3, vga_plot  out  1: pixel write port.

Function
REQ-017 FSM states SHALL be IDLE, FILL, DONE.
- IDLE->FILL on the first clock with any request high.
- FILL->DONE after the last pixel.
- DONE->IDLE when the request drops.
REQ-018 Request priority at fill start SHALL be draw_bg > erase > draw_car; the selected mode SHALL be latched for the whole fill.
REQ-019 Fill geometry SHALL be:
- bg: base (0,0), size SCREEN_W x SCREEN_H, BG_COLOUR.
- car: base (car_x,car_y), size CAR_W x CAR_H, CAR_COLOUR.
- erase: base (car_x,car_y), size CAR_W x CAR_H, BG_COLOUR.
REQ-020 Base position SHALL be captured on the IDLE->FILL transition.
REQ-021 On entering FILL, counterx and countery SHALL be 0; each FILL cycle counterx increments, wrapping to 0 at width-1 with countery incrementing (row-major).
REQ-022 In FILL, vga_plot SHALL be 1 every cycle, with vga_x=base_x+counterx, vga_y=base_y+countery (truncated to 7 bits), and vga_colour per mode.
- First plot occurs the cycle after the request is first seen.
- A fill SHALL take exactly width*height plot cycles.
REQ-023 In DONE, counterx SHALL hold the fill width (SCREEN_W or CAR_W), countery SHALL hold height-1, fill_done SHALL be 1, and vga_plot SHALL be 0.
REQ-024 If the latched request deasserts during FILL, the fill SHALL abort: next state IDLE, counters 0, vga_plot 0 from the next cycle.
REQ-025 Move commands SHALL be honoured only in IDLE or DONE and ignored in FILL; simultaneous commands take priority straight > left > right.
REQ-026 move_straight SHALL set car_y=car_y-STEP, or SCREEN_H-CAR_H if car_y<STEP (wrap).
REQ-027 move_left SHALL set car_x=car_x-STEP, saturating at 0.
REQ-028 move_right SHALL set car_x=car_x+STEP, saturating at SCREEN_W-CAR_W.
REQ-029 Position arithmetic SHALL be 9-bit internally to avoid overflow before clamping.

Reset
REQ-030 On reset the block SHALL enter IDLE with counterx=0, countery=0, fill_done=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, car_x=START_X, car_y=START_Y.
REQ-031 Reset SHALL override any request or move in the same cycle, including mid-fill.

Verification
REQ-032 Reset, hold draw_car -> 16 plots covering x 78..81, y 100..103, colour 3'b100; then fill_done=1, counterx=4.
REQ-033 Hold draw_bg -> exactly 19200 plots, first (0,0), last (159,119), colour 3'b010; then counterx=160, countery=119.
REQ-034 40 move_right pulses from reset -> car_x saturates at 156; a following draw_car plots x 156..159.
REQ-035 car_y=0 plus one move_straight -> car_y=116; all three moves in one cycle -> only straight applied.
REQ-036 Drop draw_bg after 50 plots -> vga_plot=0 next cycle, counters 0, IDLE; a new draw_car restarts at (0,0) offset.
REQ-037 Pulse move_left during a car fill -> position unchanged, fill pixels unaffected; reset asserted mid-fill -> IDLE with all outputs at their reset values.

Source files
------------

// File: rtl/car_datapath.sv
// Car game drawing datapath: fills the background, draws the car or erases it
// one pixel per clock, and keeps track of the car position for move commands.
module car_datapath (
  input  logic       clock,
  input  logic       reset,
  input  logic       draw_bg,
  input  logic       draw_car,
  input  logic       erase,
  input  logic       move_straight,
  input  logic       move_left,
  input  logic       move_right,
  output logic [7:0] counterx,
  output logic [7:0] countery,
  output logic       fill_done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  localparam logic [7:0] SCREEN_W   = 8'd160;
  localparam logic [7:0] SCREEN_H   = 8'd120;
  localparam logic [7:0] CAR_W      = 8'd4;
  localparam logic [7:0] CAR_H      = 8'd4;
  localparam logic [7:0] START_X    = 8'd78;
  localparam logic [6:0] START_Y    = 7'd100;
  localparam logic [8:0] STEP       = 9'd2;
  localparam logic [2:0] BG_COLOUR  = 3'b010;
  localparam logic [2:0] CAR_COLOUR = 3'b100;
  localparam logic [8:0] MAX_X      = {1'b0, SCREEN_W - CAR_W};
  localparam logic [8:0] WRAP_Y     = {1'b0, SCREEN_H - CAR_H};

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;
  typedef enum logic [1:0] {M_BG, M_ERASE, M_CAR} mode_t;

  state_t      r_state, w_next_state;
  mode_t       r_mode, w_new_mode;
  logic [7:0]  r_cx, r_cy;
  logic [7:0]  r_base_x, r_car_x;
  logic [6:0]  r_base_y, r_car_y;
  logic [7:0]  w_width, w_height;
  logic        w_any_req, w_req_held, w_last;
  logic [8:0]  w_x_dec, w_x_inc, w_y_dec;

  assign w_any_req  = draw_bg | draw_car | erase;
  assign w_new_mode = draw_bg ? M_BG : (erase ? M_ERASE : M_CAR);
  assign w_width    = (r_mode == M_BG) ? SCREEN_W : CAR_W;
  assign w_height   = (r_mode == M_BG) ? SCREEN_H : CAR_H;
  assign w_req_held = (r_mode == M_BG)    ? draw_bg :
                      (r_mode == M_ERASE) ? erase   : draw_car;
  assign w_last     = (r_cx == w_width - 8'd1) && (r_cy == w_height - 8'd1);

  // 9-bit position arithmetic so under/overflow is visible before clamping.
  assign w_x_dec = {1'b0, r_car_x} - STEP;
  assign w_x_inc = {1'b0, r_car_x} + STEP;
  assign w_y_dec = {2'b00, r_car_y} - STEP;

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: every signal gets a default first so no latch is inferred.
    w_next_state = r_state;
    vga_plot     = 1'b0;
    vga_x        = 8'd0;
    vga_y        = 7'd0;
    vga_colour   = 3'b000;
    fill_done    = 1'b0;
    case (r_state)
      S_IDLE: if (w_any_req) w_next_state = S_FILL;
      S_FILL: begin
        vga_plot   = 1'b1;
        vga_x      = r_base_x + r_cx;
        vga_y      = r_base_y + r_cy[6:0];
        vga_colour = (r_mode == M_CAR) ? CAR_COLOUR : BG_COLOUR;
        if (!w_req_held) w_next_state = S_IDLE;
        else if (w_last) w_next_state = S_DONE;
      end
      S_DONE: begin
        fill_done = 1'b1;
        if (!w_req_held) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign counterx = r_cx;
  assign countery = r_cy;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cx     <= 8'd0;
      r_cy     <= 8'd0;
      r_mode   <= M_BG;
      r_base_x <= 8'd0;
      r_base_y <= 7'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cx <= 8'd0;
          r_cy <= 8'd0;
          if (w_any_req) begin
            r_mode   <= w_new_mode;
            r_base_x <= (w_new_mode == M_BG) ? 8'd0 : r_car_x;
            r_base_y <= (w_new_mode == M_BG) ? 7'd0 : r_car_y;
          end
        end
        S_FILL: begin
          if (!w_req_held) begin
            r_cx <= 8'd0;
            r_cy <= 8'd0;
          end else if (w_last) begin
            r_cx <= w_width;
          end else if (r_cx == w_width - 8'd1) begin
            r_cx <= 8'd0;
            r_cy <= r_cy + 8'd1;
          end else begin
            r_cx <= r_cx + 8'd1;
          end
        end
        S_DONE: begin
          if (!w_req_held) begin
            r_cx <= 8'd0;
            r_cy <= 8'd0;
          end
        end
        default: begin
          r_cx <= 8'd0;
          r_cy <= 8'd0;
        end
      endcase
    end
  end

  // Moves are ignored while a fill is in progress; straight > left > right.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_car_x <= START_X;
      r_car_y <= START_Y;
    end else if (r_state != S_FILL) begin
      if (move_straight)
        r_car_y <= (w_y_dec > WRAP_Y) ? WRAP_Y[6:0] : w_y_dec[6:0];
      else if (move_left)
        r_car_x <= w_x_dec[8] ? 8'd0 : w_x_dec[7:0];
      else if (move_right)
        r_car_x <= (w_x_inc > MAX_X) ? MAX_X[7:0] : w_x_inc[7:0];
    end
  end

endmodule
